// File: rtl/sram_arbiter_nport.sv
// N-client round-robin arbiter for a single external async SRAM (req/ack per client).
// Optional SRAM_ARB_PRIO0_EN: client 0 gets strict priority over the round-robin group.
module sram_arbiter_nport #(
  parameter int NCLIENTS      = 4,
  parameter int AW            = 19,
  parameter int DW            = 8,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NCLIENTS-1:0]    req,
  input  logic [NCLIENTS-1:0]    we_n,
  input  logic [NCLIENTS*AW-1:0] addr,
  input  logic [NCLIENTS*DW-1:0] wdata,
  output logic [NCLIENTS-1:0]    ack,
  output logic [DW-1:0]          rdata,
  output logic                   busy,
  output logic [AW-1:0]          sram_a,
  inout  wire  [DW-1:0]          sram_d,
  output logic                   sram_we_n
);

  localparam int IW = $clog2(NCLIENTS);
  localparam int CW = $clog2(ACCESS_CYCLES);
  localparam logic [CW-1:0] CNT_INIT = CW'(ACCESS_CYCLES - 1);
  localparam logic [IW-1:0] RR_INIT  = IW'(NCLIENTS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         win_q, win_d;
  logic [IW-1:0]         rr_ptr_q, rr_ptr_d;
  logic                  wr_q, wr_d;
  logic [DW-1:0]         wdata_q, wdata_d;
  logic [AW-1:0]         sram_a_q, sram_a_d;
  logic [DW-1:0]         rdata_q, rdata_d;
  logic [NCLIENTS-1:0]   ack_q, ack_d;
  logic                  we_n_q, we_n_d;
  logic                  drive_q, drive_d;
  logic                  busy_q, busy_d;

  logic                  rr_found;
  logic [IW-1:0]         rr_win;
  logic                  grant_any;
  logic [IW-1:0]         grant_id;
  logic                  rr_upd;

  // Round-robin search: first requester after rr_ptr, wrapping modulo NCLIENTS.
  always_comb begin
    rr_found = 1'b0;
    rr_win   = '0;
    for (int k = 1; k <= NCLIENTS; k++) begin
      if (!rr_found && req[(int'(rr_ptr_q) + k) % NCLIENTS]) begin
        rr_found = 1'b1;
        rr_win   = IW'((int'(rr_ptr_q) + k) % NCLIENTS);
      end else begin
        rr_found = rr_found;
      end
    end
  end

  // Winner selection; with priority enabled client 0 bypasses the rotation and leaves rr_ptr alone.
  always_comb begin
`ifdef SRAM_ARB_PRIO0_EN
    grant_any = |req;
    if (req[0]) begin
      grant_id = '0;
      rr_upd   = 1'b0;
    end else begin
      grant_id = rr_win;
      rr_upd   = 1'b1;
    end
`else
    grant_any = rr_found;
    grant_id  = rr_win;
    rr_upd    = 1'b1;
`endif
  end

  // Access sequencer: latch at grant, hold address for the window, ack in DONE.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    win_d    = win_q;
    rr_ptr_d = rr_ptr_q;
    wr_d     = wr_q;
    wdata_d  = wdata_q;
    sram_a_d = sram_a_q;
    rdata_d  = rdata_q;
    ack_d    = '0;
    we_n_d   = 1'b1;
    drive_d  = drive_q;
    case (state_q)
      IDLE: begin
        if (grant_any) begin
          state_d  = ACCESS;
          cnt_d    = CNT_INIT;
          win_d    = grant_id;
          wr_d     = ~we_n[grant_id];
          drive_d  = ~we_n[grant_id];
          sram_a_d = addr[int'(grant_id)*AW +: AW];
          wdata_d  = wdata[int'(grant_id)*DW +: DW];
          if (rr_upd) begin
            rr_ptr_d = grant_id;
          end else begin
            rr_ptr_d = rr_ptr_q;
          end
        end else begin
          state_d = IDLE;
          drive_d = 1'b0;
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          state_d        = DONE;
          ack_d[win_q]   = 1'b1;
          if (!wr_q) begin
            rdata_d = sram_d;
          end else begin
            rdata_d = rdata_q;
          end
        end else begin
          cnt_d  = cnt_q - CW'(1);
          // First ACCESS cycle is address setup; strobe low for the rest of the window.
          we_n_d = ~wr_q;
        end
      end
      DONE: begin
        state_d = IDLE;
        drive_d = 1'b0;
      end
      default: begin
        state_d = IDLE;
        drive_d = 1'b0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset aborts any access with no ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      win_q    <= '0;
      rr_ptr_q <= RR_INIT;
      wr_q     <= 1'b0;
      wdata_q  <= '0;
      sram_a_q <= '0;
      rdata_q  <= '0;
      ack_q    <= '0;
      we_n_q   <= 1'b1;
      drive_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      win_q    <= win_d;
      rr_ptr_q <= rr_ptr_d;
      wr_q     <= wr_d;
      wdata_q  <= wdata_d;
      sram_a_q <= sram_a_d;
      rdata_q  <= rdata_d;
      ack_q    <= ack_d;
      we_n_q   <= we_n_d;
      drive_q  <= drive_d;
      busy_q   <= busy_d;
    end
  end

  assign ack       = ack_q;
  assign rdata     = rdata_q;
  assign busy      = busy_q;
  assign sram_a    = sram_a_q;
  assign sram_we_n = we_n_q;
  assign sram_d    = drive_q ? wdata_q : {DW{1'bz}};

endmodule
